// File: rtl/beat_scheduler.sv
// beat_scheduler
// Beat generator for a 16-step sequencer.
// STOP/PLAY/PAUSE FSM driven by one-cycle button pulses. While playing, a
// period counter produces one beat_tick every `period` clk cycles and steps
// beat_idx through 0..15.
//
// Ports:
//   clk        - sole clock, rising edge
//   rst_n      - asynchronous active-low reset
//   btn_play   - one-cycle play/pause toggle pulse (debounced)
//   btn_stop   - one-cycle stop pulse (debounced), wins over btn_play
//   tempo_sel  - beat period select: 0 slow, 1 medium, 2/3 fast
//   loop_en    - 1 = wrap after beat 15, 0 = end the sequence after beat 15
//   play_pause - high while in PLAY (LED chaser enable)
//   beat_tick  - one-cycle strobe per beat (LED chaser step)
//   beat_idx   - current beat number 0..15
//   state      - 2'b00 STOP, 2'b01 PLAY, 2'b10 PAUSE
//   done       - one-cycle strobe when a non-looping sequence ends
// All outputs come straight from flops.
module beat_scheduler #(
   parameter int unsigned TICKS_SLOW = 32'd50_000_000,
   parameter int unsigned TICKS_MED  = 32'd25_000_000,
   parameter int unsigned TICKS_FAST = 32'd12_500_000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       btn_play,
   input  logic       btn_stop,
   input  logic [1:0] tempo_sel,
   input  logic       loop_en,
   output logic       play_pause,
   output logic       beat_tick,
   output logic [3:0] beat_idx,
   output logic [1:0] state,
   output logic       done
);

   localparam logic [1:0] ST_STOP  = 2'b00;
   localparam logic [1:0] ST_PLAY  = 2'b01;
   localparam logic [1:0] ST_PAUSE = 2'b10;

   // Beat period in clk cycles for a given tempo selection.
   function automatic logic [31:0] tempo_period(input logic [1:0] sel);
      logic [31:0] p;
      case (sel)
         2'd0:    p = 32'(TICKS_SLOW);
         2'd1:    p = 32'(TICKS_MED);
         default: p = 32'(TICKS_FAST);
      endcase
      return p;
   endfunction

   logic [1:0]  state_r, state_s;
   logic [31:0] cnt_r, cnt_s;
   logic [31:0] period_r, period_s;
   logic [3:0]  idx_r, idx_s;
   logic        tick_r, tick_s;
   logic        done_r, done_s;
   logic        pp_r;
   logic        terminal_s;

   // Last cycle of the current beat.
   assign terminal_s = (cnt_r == (period_r - 32'd1));

   // Next-state logic for FSM, period counter, beat index and strobes.
   always_comb begin
      state_s  = state_r;
      cnt_s    = cnt_r;
      period_s = period_r;
      idx_s    = idx_r;
      tick_s   = 1'b0;
      done_s   = 1'b0;
      if (btn_stop) begin
         // Stop wins over everything, including a coincident terminal count.
         state_s = ST_STOP;
         cnt_s   = 32'd0;
         idx_s   = 4'd0;
      end else begin
         case (state_r)
            ST_STOP: begin
               cnt_s = 32'd0;
               idx_s = 4'd0;
               if (btn_play) begin
                  state_s  = ST_PLAY;
                  period_s = tempo_period(tempo_sel);
               end else begin
                  state_s = ST_STOP;
               end
            end
            ST_PLAY: begin
               if (terminal_s) begin
                  // Beat boundary: tempo is re-sampled only here.
                  cnt_s    = 32'd0;
                  tick_s   = 1'b1;
                  period_s = tempo_period(tempo_sel);
                  if (idx_r == 4'd15) begin
                     idx_s = 4'd0;
                     if (!loop_en) begin
                        // End of sequence overrides a coincident pause.
                        state_s = ST_STOP;
                        done_s  = 1'b1;
                     end else if (btn_play) begin
                        state_s = ST_PAUSE;
                     end else begin
                        state_s = ST_PLAY;
                     end
                  end else begin
                     idx_s = idx_r + 4'd1;
                     if (btn_play) begin
                        state_s = ST_PAUSE;
                     end else begin
                        state_s = ST_PLAY;
                     end
                  end
               end else begin
                  cnt_s = cnt_r + 32'd1;
                  if (btn_play) begin
                     state_s = ST_PAUSE;
                  end else begin
                     state_s = ST_PLAY;
                  end
               end
            end
            ST_PAUSE: begin
               // cnt, idx and period hold so the partial beat resumes.
               if (btn_play) begin
                  state_s = ST_PLAY;
               end else begin
                  state_s = ST_PAUSE;
               end
            end
            default: begin
               state_s = ST_STOP;
               cnt_s   = 32'd0;
               idx_s   = 4'd0;
            end
         endcase
      end
   end

   // State and output registers with asynchronous reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r  <= ST_STOP;
         cnt_r    <= 32'd0;
         period_r <= 32'(TICKS_SLOW);
         idx_r    <= 4'd0;
         tick_r   <= 1'b0;
         done_r   <= 1'b0;
         pp_r     <= 1'b0;
      end else begin
         state_r  <= state_s;
         cnt_r    <= cnt_s;
         period_r <= period_s;
         idx_r    <= idx_s;
         tick_r   <= tick_s;
         done_r   <= done_s;
         pp_r     <= (state_s == ST_PLAY);
      end
   end

   assign play_pause = pp_r;
   assign beat_tick  = tick_r;
   assign beat_idx   = idx_r;
   assign state      = state_r;
   assign done       = done_r;

endmodule

// File: tb/tb_beat_scheduler.sv
// Self-checking bench for beat_scheduler with small beat periods.
// A countdown-style reference model predicts every output each cycle; a few
// hand-computed expectations pin the model to known timing.
module tb_beat_scheduler;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       btn_play = 1'b0;
   logic       btn_stop = 1'b0;
   logic [1:0] tempo_sel = 2'd0;
   logic       loop_en = 1'b1;
   logic       play_pause;
   logic       beat_tick;
   logic [3:0] beat_idx;
   logic [1:0] state;
   logic       done;

   int n_tests = 0;
   int n_fail  = 0;
   int gap;

   beat_scheduler #(
      .TICKS_SLOW(32'd4),
      .TICKS_MED (32'd3),
      .TICKS_FAST(32'd2)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .btn_play  (btn_play),
      .btn_stop  (btn_stop),
      .tempo_sel (tempo_sel),
      .loop_en   (loop_en),
      .play_pause(play_pause),
      .beat_tick (beat_tick),
      .beat_idx  (beat_idx),
      .state     (state),
      .done      (done)
   );

   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   // mode: 0 stop, 1 play, 2 pause; rem = play cycles left until next beat.
   typedef struct packed {
      logic [1:0]  mode;
      logic [31:0] rem;
      logic [3:0]  beat;
      logic        tick;
      logic        done;
   } model_t;

   model_t m;

   function automatic logic [31:0] per_of(input logic [1:0] sel);
      if (sel == 2'd0) return 32'd4;
      else if (sel == 2'd1) return 32'd3;
      else return 32'd2;
   endfunction

   function automatic model_t model_step(input model_t c, input logic p, input logic s,
                                         input logic [1:0] sel, input logic lp);
      model_t n;
      n = c;
      n.tick = 1'b0;
      n.done = 1'b0;
      if (s) begin
         n.mode = 2'd0;
         n.beat = 4'd0;
         n.rem  = 32'd0;
      end else if (c.mode == 2'd0) begin
         if (p) begin
            n.mode = 2'd1;
            n.rem  = per_of(sel);
            n.beat = 4'd0;
         end
      end else if (c.mode == 2'd2) begin
         if (p) n.mode = 2'd1;
      end else begin
         n.rem = c.rem - 32'd1;
         if (p) n.mode = 2'd2;
         if (n.rem == 32'd0) begin
            n.tick = 1'b1;
            n.rem  = per_of(sel);
            n.beat = c.beat + 4'd1;
            if (c.beat == 4'd15 && !lp) begin
               n.mode = 2'd0;
               n.done = 1'b1;
               n.rem  = 32'd0;
            end
         end
      end
      return n;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) m <= '0;
      else m <= model_step(m, btn_play, btn_stop, tempo_sel, loop_en);
   end

   // ---------------- checking ----------------
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Per-cycle compare of every output against the model.
   always @(negedge clk) begin
      check("state",      32'(state),      32'(m.mode));
      check("play_pause", 32'(play_pause), 32'(m.mode == 2'd1));
      check("beat_tick",  32'(beat_tick),  32'(m.tick));
      check("beat_idx",   32'(beat_idx),   32'(m.beat));
      check("done",       32'(done),       32'(m.done));
   end

   task automatic step(input logic p, input logic s);
      @(negedge clk);
      #1;
      btn_play = p;
      btn_stop = s;
   endtask

   // Counts cycles until beat_tick is seen; called just after a clock edge.
   task automatic wait_tick(output int n);
      n = 0;
      do begin
         step(1'b0, 1'b0);
         @(posedge clk);
         #2;
         n++;
      end while (beat_tick !== 1'b1 && n < 40);
      if (n >= 40) check("tick_timeout", 32'(beat_tick), 32'd1);
   endtask

   initial begin
      rst_n = 1'b1;
      #1 rst_n = 1'b0;
      #3;
      check("rst_state", 32'(state), 32'd0);
      check("rst_pp",    32'(play_pause), 32'd0);
      check("rst_tick",  32'(beat_tick), 32'd0);
      check("rst_idx",   32'(beat_idx), 32'd0);
      check("rst_done",  32'(done), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // Play at slow tempo: 4-cycle beats, idx counting up.
      tempo_sel = 2'd0;
      loop_en   = 1'b1;
      step(1'b1, 1'b0);
      @(posedge clk); #2;
      check("play_pp", 32'(play_pause), 32'd1);
      check("play_state", 32'(state), 32'd1);
      wait_tick(gap);
      check("first_gap", 32'(gap), 32'd4);
      check("idx_after_1", 32'(beat_idx), 32'd1);
      wait_tick(gap);
      check("second_gap", 32'(gap), 32'd4);
      check("idx_after_2", 32'(beat_idx), 32'd2);

      // Pause two cycles into a beat, hold 10 cycles, resume.
      step(1'b0, 1'b0);
      step(1'b1, 1'b0);
      repeat (10) step(1'b0, 1'b0);
      @(posedge clk); #2;
      check("pause_state", 32'(state), 32'd2);
      check("pause_idx", 32'(beat_idx), 32'd2);
      step(1'b1, 1'b0);
      @(posedge clk); #2;
      check("resume_pp", 32'(play_pause), 32'd1);
      wait_tick(gap);
      check("resume_gap", 32'(gap), 32'd2);
      check("resume_idx", 32'(beat_idx), 32'd3);

      // Tempo change mid-beat: current beat stays 4, next beats 2.
      step(1'b0, 1'b0);
      tempo_sel = 2'd2;
      @(posedge clk); #2;
      wait_tick(gap);
      check("tempo_old_gap", 32'(gap), 32'd3);
      wait_tick(gap);
      check("tempo_new_gap", 32'(gap), 32'd2);
      check("tempo_idx", 32'(beat_idx), 32'd5);

      // Looping wrap 15 -> 0 stays in PLAY.
      repeat (10) wait_tick(gap);
      check("loop_idx15", 32'(beat_idx), 32'd15);
      wait_tick(gap);
      check("loop_wrap_idx", 32'(beat_idx), 32'd0);
      check("loop_state", 32'(state), 32'd1);

      // Non-looping end of sequence.
      loop_en = 1'b0;
      repeat (16) wait_tick(gap);
      check("end_idx", 32'(beat_idx), 32'd0);
      check("end_state", 32'(state), 32'd0);
      check("end_done", 32'(done), 32'd1);
      step(1'b0, 1'b0);
      @(posedge clk); #2;
      check("end_done_clr", 32'(done), 32'd0);

      // Play and stop in the same cycle while playing.
      loop_en = 1'b1;
      step(1'b1, 1'b0);
      step(1'b0, 1'b0);
      step(1'b1, 1'b1);
      @(posedge clk); #2;
      check("both_state", 32'(state), 32'd0);
      check("both_tick", 32'(beat_tick), 32'd0);
      check("both_idx", 32'(beat_idx), 32'd0);

      // Asynchronous reset between edges while playing.
      tempo_sel = 2'd0;
      step(1'b1, 1'b0);
      repeat (6) step(1'b0, 1'b0);
      @(posedge clk); #2;
      rst_n = 1'b0;
      #1;
      check("arst_state", 32'(state), 32'd0);
      check("arst_pp", 32'(play_pause), 32'd0);
      check("arst_idx", 32'(beat_idx), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (6) step(1'b0, 1'b0);
      @(posedge clk); #2;
      check("arst_stay_stop", 32'(state), 32'd0);
      step(1'b1, 1'b0);
      @(posedge clk); #2;
      wait_tick(gap);
      check("arst_gap", 32'(gap), 32'd4);

      // Randomized phase, checked cycle by cycle against the model.
      for (int i = 0; i < 4000; i++) begin
         @(negedge clk);
         #1;
         btn_play = ($urandom_range(0, 11) == 0);
         btn_stop = ($urandom_range(0, 59) == 0);
         if ($urandom_range(0, 15) == 0) tempo_sel = 2'($urandom_range(0, 3));
         if ($urandom_range(0, 79) == 0) loop_en = ~loop_en;
         if ($urandom_range(0, 699) == 0) begin
            #2 rst_n = 1'b0;
            #1 rst_n = 1'b1;
         end
      end
      step(1'b0, 1'b0);
      repeat (3) @(negedge clk);
      #1;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
